// File: rtl/pmp_pkg.sv
// Shared types for the instruction-fetch PMP checker: address-mode enum,
// packed pmpcfg byte layout and the permission rule helpers used in stage s2.
// Optional feature macro: BIRIQ_SMEPMP_EN (enables the Smepmp MML rules).
package pmp_pkg;

  localparam int PMP_MAX_ENTRIES = 16;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    TOR   = 2'd1,
    NA4   = 2'd2,
    NAPOT = 2'd3
  } pmp_mode_e;

  typedef struct packed {
    logic      l;
    logic [1:0] rsvd;
    pmp_mode_e a;
    logic      x;
    logic      w;
    logic      r;
  } pmp_cfg_t;

  // Classic PMP execute rule; M-mode is only constrained by locked entries.
  function automatic logic legacy_exec(logic hit, logic m_mode, logic l, logic x);
    if (!hit)        return m_mode;
    else if (m_mode) return l ? x : 1'b1;
    else             return x;
  endfunction

  // Smepmp MML execute rule for a matching entry; no-hit is handled by the caller.
  function automatic logic mml_exec(logic m_mode, logic l, logic r, logic w, logic x);
    logic [2:0] rwx;
    rwx = {r, w, x};
    if (m_mode) begin
      return l && (rwx == 3'b001 || rwx == 3'b101 || rwx == 3'b010 || rwx == 3'b011);
    end
    return (!l && (rwx == 3'b001 || rwx == 3'b101 || rwx == 3'b111)) ||
           ( l && (rwx == 3'b010 || rwx == 3'b011));
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational address match of one PMP entry against a fetch granule.
// NAPOT uses addr ^ (addr + 1) to mark the trailing ones plus the first zero
// as don't-care bits; an all-ones pmpaddr therefore matches everything.
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int GRAN_W = 30
) (
  input  logic [1:0]        mode,
  input  logic [GRAN_W-1:0] addr,
  input  logic [GRAN_W-1:0] prev,
  input  logic [GRAN_W-1:0] gran,
  output logic              match
);

  logic [GRAN_W-1:0] napot_care;

  assign napot_care = ~(addr ^ (addr + {{(GRAN_W-1){1'b0}}, 1'b1}));

  // Select the comparison implied by the entry's address mode
  always_comb begin
    match = 1'b0;
    case (pmp_mode_e'(mode))
      OFF:     match = 1'b0;
      TOR:     match = (gran >= prev) && (gran < addr);
      NA4:     match = (gran == addr);
      NAPOT:   match = ((gran & napot_care) == (addr & napot_care));
      default: match = 1'b0;
    endcase
  end

endmodule

// File: rtl/i_pmp_checker.sv
// Two-stage valid/ready PMP checker for instruction fetch.
// s1 registers the per-entry match vector and sampled privilege; s2 priority
// encodes, applies the permission rules and drives the held rsp_* outputs.
// CSR writes are only taken while the pipeline is empty, so s2 may read the
// live cfg registers. Optional feature macro: BIRIQ_SMEPMP_EN.
module i_pmp_checker
  import pmp_pkg::*;
#(
  parameter  int PMP_ENTRIES = 8,
  parameter  int PADDR_W     = 32,
  localparam int IDX_W       = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1
) (
  input  logic               cpu_clock_i,
  input  logic               cpu_resetn_i,
  output logic               csr_ready_o,
  input  logic               cfg_we_i,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [7:0]         cfg_wdata_i,
  input  logic               addr_we_i,
  input  logic [IDX_W-1:0]   addr_idx_i,
  input  logic [PADDR_W-3:0] addr_wdata_i,
  input  logic               m_mode_i,
  input  logic               mml_i,
  input  logic               flush_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic [PADDR_W-1:0] req_addr_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic               rsp_exec_o,
  output logic               rsp_hit_o,
  output logic [IDX_W-1:0]   rsp_idx_o
);

  localparam int GW = PADDR_W - 2;

  pmp_cfg_t                cfg  [PMP_ENTRIES];
  logic     [GW-1:0]       addr [PMP_ENTRIES];
  logic     [PMP_ENTRIES-1:0] match_vec;
  logic     [PMP_ENTRIES-1:0] addr_locked;
  logic     [PMP_ENTRIES-1:0] s1_match;
  logic                    s1_valid;
  logic                    s1_m_mode;
  logic                    s2_hold;
  logic                    s1_adv;
  logic                    req_accept;
  logic     [GW-1:0]       gran;
  logic                    win_hit;
  logic     [IDX_W-1:0]    win_idx;
  pmp_cfg_t                win_cfg;
  logic                    win_exec;
  logic                    unused_addr_bits;
  logic                    unused_cfg_bits;

  assign gran             = req_addr_i[PADDR_W-1:2];
  assign unused_addr_bits = ^req_addr_i[1:0];
  assign unused_cfg_bits  = ^{win_cfg.rsvd, win_cfg.r, win_cfg.w};

  assign csr_ready_o = !s1_valid && !rsp_valid_o;
  assign s2_hold     = rsp_valid_o && !rsp_ready_i;
  assign s1_adv      = s1_valid && !s2_hold;
  assign req_ready_o = (!s1_valid || s1_adv) && !cfg_we_i && !addr_we_i && !flush_i;
  assign req_accept  = req_valid_i && req_ready_o;

  for (genvar g = 0; g < PMP_ENTRIES; g++) begin : g_entry
    logic [GW-1:0] prev;
    if (g == 0) begin : g_first
      assign prev = '0;
    end else begin : g_rest
      assign prev = addr[g-1];
    end
    // A locked TOR entry also freezes the pmpaddr below it (its base)
    if (g < PMP_ENTRIES - 1) begin : g_lock_next
      assign addr_locked[g] = cfg[g].l || (cfg[g+1].l && cfg[g+1].a == TOR);
    end else begin : g_lock_last
      assign addr_locked[g] = cfg[g].l;
    end
    pmp_entry_match #(.GRAN_W(GW)) u_match (
      .mode  (cfg[g].a),
      .addr  (addr[g]),
      .prev  (prev),
      .gran  (gran),
      .match (match_vec[g])
    );
  end

  // CSR writes to cfg/addr, honouring lock bits and the empty-pipeline gate
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        cfg[i]  <= '0;
        addr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PMP_ENTRIES; i++) begin
        if (cfg_we_i && csr_ready_o && cfg_idx_i == IDX_W'(i) && !cfg[i].l) begin
          cfg[i] <= pmp_cfg_t'({cfg_wdata_i[7], 2'b00, cfg_wdata_i[4:0]});
        end
        if (addr_we_i && csr_ready_o && addr_idx_i == IDX_W'(i) && !addr_locked[i]) begin
          addr[i] <= addr_wdata_i;
        end
      end
    end
  end

  // Stage s1: capture match vector and privilege of the accepted request
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      s1_valid  <= 1'b0;
      s1_match  <= '0;
      s1_m_mode <= 1'b0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else if (req_accept) begin
      s1_valid  <= 1'b1;
      s1_match  <= match_vec;
      s1_m_mode <= m_mode_i;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

`ifdef BIRIQ_SMEPMP_EN
  logic s1_mml;

  // Capture mseccfg.MML alongside the request
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      s1_mml <= 1'b0;
    end else if (req_accept) begin
      s1_mml <= mml_i;
    end
  end
`else
  logic unused_mml;
  assign unused_mml = mml_i;
`endif

  // Lowest-index priority encode and execute-permission evaluation
  always_comb begin
    win_hit = 1'b0;
    win_idx = '0;
    win_cfg = '0;
    for (int i = PMP_ENTRIES - 1; i >= 0; i--) begin
      if (s1_match[i]) begin
        win_hit = 1'b1;
        win_idx = IDX_W'(i);
        win_cfg = cfg[i];
      end
    end
    win_exec = legacy_exec(win_hit, s1_m_mode, win_cfg.l, win_cfg.x);
`ifdef BIRIQ_SMEPMP_EN
    if (s1_mml) begin
      win_exec = win_hit && mml_exec(s1_m_mode, win_cfg.l, win_cfg.r, win_cfg.w, win_cfg.x);
    end
`endif
  end

  // Stage s2: register the response and hold it while the consumer stalls
  always_ff @(posedge cpu_clock_i or negedge cpu_resetn_i) begin
    if (!cpu_resetn_i) begin
      rsp_valid_o <= 1'b0;
      rsp_exec_o  <= 1'b0;
      rsp_hit_o   <= 1'b0;
      rsp_idx_o   <= '0;
    end else if (flush_i) begin
      rsp_valid_o <= 1'b0;
    end else if (s1_adv) begin
      rsp_valid_o <= 1'b1;
      rsp_exec_o  <= win_exec;
      rsp_hit_o   <= win_hit;
      rsp_idx_o   <= win_idx;
    end else if (rsp_ready_i) begin
      rsp_valid_o <= 1'b0;
    end
  end

endmodule
